song_slot_sequencer: RTL
========================

// Module: song_slot_sequencer
// PURPOSE
//   Owns the single-port song RAM shared by the record and playback paths of free mode.
//   Sequences recording of keyboard notes into NUM_SLOTS song slots and looped playback of a chosen slot.
//   Tracks the recorded length of each slot.
//   Erases all slots on a long press of the clear button.
//   Sits between the key decoder (note/octave in) and the tone generator (note/octave out).
// PARAMETERS
//   NUM_SLOTS   3          number of song slots (1..4)
//   ADDR_WIDTH  8          per-slot address width
//   SLOT_DEPTH  200        notes per slot, <= 2**ADDR_WIDTH
//   TICK_DIV    10000000   clk cycles per note tick (0.1 s @ 100 MHz)
//   HOLD_TICKS  20         ticks clear_btn must be held to erase (2 s)
// PORTS
//   clk         in   1            system clock
//   reset       in   1            synchronous, active-low
//   rec_en      in   1            record switch (level)
//   play_req    in   1            play switch (level)
//   slot_sel    in   2            slot to play
//   clear_btn   in   1            erase button (level)
//   note_in     in   4            current key note, 0 = rest
//   oct_in      in   2            current octave
//   ram_en      out  1            RAM access strobe
//   ram_we      out  1            RAM write enable
//   ram_addr    out  2+ADDR_WIDTH {slot, index}
//   ram_wdata   out  6            {oct, note}
//   ram_rdata   in   6            read data, valid 1 cycle after ram_en & !ram_we
//   note_out    out  4            playback note
//   oct_out     out  2            playback octave
//   note_valid  out  1            1-cycle pulse when note_out/oct_out update
//   state_out   out  2            0 IDLE, 1 RECORD, 2 PLAY, 3 CLEAR
//   cur_slot    out  2            slot being recorded/played; next record slot when IDLE
//   clear_done  out  1            1-cycle pulse after erase
// BEHAVIOUR
//   Reset (reset==0 at posedge clk, dominates mid-operation):
//   - All outputs 0; state IDLE.
//   - len[*]=0, wr_slot=0, tick counter=0, hold counter=0.
//   rec_en/clear_btn/play_req: synchronous inputs, edge-detected against a 1-cycle registered copy.
//   Tick:
//   - Counter runs 0..TICK_DIV-1; tick=1 for one cycle at TICK_DIV-1.
//   - Counter zeroed on entry to RECORD/PLAY, so the first tick is TICK_DIV cycles after entry.
//   IDLE (priority: record > play > clear):
//   - rec_en rise -> RECORD; slot=wr_slot, wr_idx=0.
//   - Else play_req==1, slot_sel<NUM_SLOTS and len[slot_sel]!=0 -> PLAY; slot=slot_sel, rd_idx=0.
//   - play_req on an empty or invalid slot: stay IDLE.
//   - Else clear_btn high: hold counter +1 per tick, zeroed on release.
//     On reaching HOLD_TICKS -> CLEAR.
//   RECORD:
//   - Each tick with wr_idx<SLOT_DEPTH: ram_en=ram_we=1 for that cycle.
//     addr={slot,wr_idx}, wdata={oct_in,note_in}; wr_idx+1.
//   - At wr_idx==SLOT_DEPTH: further ticks ignored (saturate, no write).
//   - rec_en fall -> len[slot]=wr_idx; IDLE.
//     If wr_idx!=0, wr_slot=(wr_slot+1) mod NUM_SLOTS; else wr_slot unchanged.
//   PLAY:
//   - Each tick: ram_en=1, ram_we=0, addr={slot,rd_idx}.
//   - Next cycle: note_out/oct_out <= ram_rdata; note_valid=1.
//   - rd_idx wraps to 0 after len[slot]-1 (loop).
//   - play_req fall -> IDLE; note_out=0, oct_out=0 in the same cycle.
//     No note_valid for a read already in flight.
//   - rec_en rise in PLAY: abort playback (outputs to 0), enter RECORD as from IDLE.
//   - slot_sel changes while in PLAY: ignored.
//   CLEAR: one cycle.
//   - len[*]=0, wr_slot=0, hold counter=0; clear_done=1.
//   - -> IDLE. RAM contents untouched; len gates access.
//   RAM: ram_en=0 except in access cycles; ram_we=1 only on RECORD write cycles.
//     At most one access per cycle.
//   note_out/oct_out hold their last value between ticks in PLAY; 0 in IDLE, RECORD, CLEAR.
// TESTING (TICK_DIV=4, SLOT_DEPTH=5, HOLD_TICKS=3)
//   Record: rec_en high for 3 ticks, notes 1,2,3 oct 1.
//     -> writes addr {0,0..2}, data 0x11,0x12,0x13; len[0]=3; cur_slot=1 in IDLE.
//   Play: play_req, slot_sel=0.
//     -> note_valid pulses every 4 clk; notes 1,2,3,1,2 (wraps).
//     play_req low -> note_out=0 same cycle.
//   Overflow: record 7 ticks into slot 1 -> exactly 5 writes; len[1]=5.
//     rec_en rise/fall with no tick -> len=0; wr_slot unchanged.
//   Empty: play_req on an empty slot or slot_sel=3 -> stays IDLE; ram_en never asserted.
//   Clear: clear_btn held 2 ticks then released -> no clear.
//     Held 3 ticks -> clear_done pulse; all len=0; cur_slot=0.
//   Priority/reset: rec_en rise during PLAY -> RECORD, outputs 0.
//     reset low mid-RECORD -> all outputs 0, len=0 next cycle.

Source files
------------

// File: rtl/song_slot_sequencer.sv
// rtl/song_slot_sequencer.sv - free-mode song RAM record/playback sequencer
//
// Records key-decoder notes into NUM_SLOTS song slots of a shared single-port
// RAM, loops playback of one slot to the tone generator, and erases all slot
// lengths on a long press of clear_btn.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   rec_en, play_req           record / play switches (levels)
//   slot_sel                   slot to play (sampled on entry to playback)
//   clear_btn                  erase button (level)
//   note_in, oct_in            live key note (0 = rest) and octave
//   ram_en, ram_we             RAM access strobe and write enable
//   ram_addr, ram_wdata        {slot, index} and {oct, note}
//   ram_rdata                  read data, one cycle after a read strobe
//   note_out, oct_out          playback note/octave, 0 outside playback
//   note_valid                 pulse when note_out/oct_out take a new value
//   state_out                  0 idle, 1 record, 2 play, 3 clear
//   cur_slot                   active slot; next record slot while idle
//   clear_done                 pulse during the erase cycle
module song_slot_sequencer #(
  parameter int NUM_SLOTS  = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int SLOT_DEPTH = 200,
  parameter int TICK_DIV   = 10000000,
  parameter int HOLD_TICKS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rec_en,
  input  logic                  play_req,
  input  logic [1:0]            slot_sel,
  input  logic                  clear_btn,
  input  logic [3:0]            note_in,
  input  logic [1:0]            oct_in,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH+1:0] ram_addr,
  output logic [5:0]            ram_wdata,
  input  logic [5:0]            ram_rdata,
  output logic [3:0]            note_out,
  output logic [1:0]            oct_out,
  output logic                  note_valid,
  output logic [1:0]            state_out,
  output logic [1:0]            cur_slot,
  output logic                  clear_done
);

  // Index is one bit wider than the address so it can hold SLOT_DEPTH itself.
  localparam int IW = ADDR_WIDTH + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [IW-1:0] DEPTH     = IW'(SLOT_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [2:0]    SLOTS     = 3'(NUM_SLOTS);
  localparam logic [1:0]    LAST_SLOT = 2'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic            rec_q, play_q;
  logic [TW-1:0]   tick_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [IW-1:0]   len [4];
  logic [1:0]      wr_slot;
  logic [1:0]      slot;
  logic [IW-1:0]   idx;          // write index in record, read index in play
  logic            rd_pending;

  logic tick, rec_rise, rec_fall, play_fall, play_ok;
  logic start_rec, start_play, end_rec, do_write, do_read, do_clear;
  logic hold_inc, hold_clr;

  assign tick      = (tick_cnt == TICK_LAST);
  assign rec_rise  = rec_en & ~rec_q;
  assign rec_fall  = ~rec_en & rec_q;
  assign play_fall = ~play_req & play_q;
  assign play_ok   = play_req && ({1'b0, slot_sel} < SLOTS) && (len[slot_sel] != '0);

  // A tick that coincides with leaving the state (switch released or
  // playback aborted) performs no RAM access.
  always_comb begin
    state_d    = state;
    start_rec  = 1'b0;
    start_play = 1'b0;
    end_rec    = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    do_clear   = 1'b0;
    hold_inc   = 1'b0;
    hold_clr   = 1'b1;
    case (state)
      S_IDLE: begin
        if (rec_rise) begin
          start_rec = 1'b1;
          state_d   = S_RECORD;
        end else if (play_ok) begin
          start_play = 1'b1;
          state_d    = S_PLAY;
        end else if (clear_btn) begin
          hold_clr = 1'b0;
          if (tick) begin
            hold_inc = 1'b1;
            if (hold_cnt == HOLD_LAST) state_d = S_CLEAR;
          end
        end
      end
      S_RECORD: begin
        if (rec_fall) begin
          end_rec = 1'b1;
          state_d = S_IDLE;
        end else if (tick && (idx < DEPTH)) begin
          do_write = 1'b1;
        end
      end
      S_PLAY: begin
        if (rec_rise) begin
          start_rec = 1'b1;
          state_d   = S_RECORD;
        end else if (play_fall) begin
          state_d = S_IDLE;
        end else if (tick) begin
          do_read = 1'b1;
        end
      end
      S_CLEAR: begin
        do_clear = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rec_q      <= 1'b0;
      play_q     <= 1'b0;
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      for (int i = 0; i < 4; i++) len[i] <= '0;
      wr_slot    <= '0;
      slot       <= '0;
      idx        <= '0;
      rd_pending <= 1'b0;
      note_out   <= '0;
      oct_out    <= '0;
      note_valid <= 1'b0;
    end else begin
      rec_q  <= rec_en;
      play_q <= play_req;

      // Restarting on entry puts the first tick a full period after entry.
      tick_cnt <= (start_rec || start_play || tick) ? '0 : tick_cnt + TW'(1);

      if (hold_clr)      hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + HW'(1);

      rd_pending <= do_read;
      note_valid <= 1'b0;

      if (start_rec) begin
        slot <= wr_slot;
        idx  <= '0;
      end
      if (start_play) begin
        slot <= slot_sel;
        idx  <= '0;
      end
      if (do_write) idx <= idx + IW'(1);
      if (do_read)  idx <= (idx == len[slot] - IW'(1)) ? '0 : idx + IW'(1);

      // Read data is only taken if playback survives the cycle it returns in.
      if (rd_pending && state_d == S_PLAY) begin
        note_out   <= ram_rdata[3:0];
        oct_out    <= ram_rdata[5:4];
        note_valid <= 1'b1;
      end
      if (state_d != S_PLAY) begin
        note_out <= '0;
        oct_out  <= '0;
      end

      // An empty take leaves the record slot where it was.
      if (end_rec) begin
        len[slot] <= idx;
        if (idx != '0) wr_slot <= (wr_slot == LAST_SLOT) ? 2'd0 : wr_slot + 2'd1;
      end

      // RAM contents stay; zero lengths are enough to make slots unplayable.
      if (do_clear) begin
        for (int i = 0; i < 4; i++) len[i] <= '0;
        wr_slot <= '0;
      end
    end
  end

  assign ram_en     = reset & (do_write | do_read);
  assign ram_we     = reset & do_write;
  assign ram_addr   = ram_en ? {slot, idx[ADDR_WIDTH-1:0]} : '0;
  assign ram_wdata  = ram_we ? {oct_in, note_in} : '0;
  assign state_out  = state;
  assign cur_slot   = (state == S_RECORD || state == S_PLAY) ? slot : wr_slot;
  assign clear_done = (state == S_CLEAR);

endmodule
